// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, state encoding and constants for the multiply-accumulate slice
//
// Purpose: default widths for the product/accumulator/run-length paths, the
// accumulator FSM state type and the all-ones saturation value.
// Ports: none (package).
package mult_pkg;

  localparam int P_WIDTH_DEF   = 32;
  localparam int ACC_WIDTH_DEF = 40;
  localparam int LEN_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Saturation value at the default accumulator width; parametrised
  // instances use '1 of their own width.
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MAX = '1;

endpackage

// File: rtl/mult_accumulator_if.sv
// rtl/mult_accumulator_if.sv - product input / result output bundle of the accumulator
//
// Purpose: groups the run control, product handshake and result handshake.
// Ports (signals):
//   clear     abort of partial run and held result
//   len       products per run (0 means 1)
//   p_in/p_valid/p_ready           product stream into the accumulator
//   acc_out/acc_valid/acc_ready    result stream out of the accumulator
//   acc_ovf   saturation flag qualifying acc_out
// Modports: master = upstream producer plus result consumer, slave = accumulator.
interface mult_accumulator_if #(
  parameter int P_WIDTH   = mult_pkg::P_WIDTH_DEF,
  parameter int ACC_WIDTH = mult_pkg::ACC_WIDTH_DEF,
  parameter int LEN_WIDTH = mult_pkg::LEN_WIDTH_DEF
) ();

  logic                 clear;
  logic [LEN_WIDTH-1:0] len;
  logic [P_WIDTH-1:0]   p_in;
  logic                 p_valid;
  logic                 p_ready;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_valid;
  logic                 acc_ready;
  logic                 acc_ovf;

  modport master (
    output clear, len, p_in, p_valid, acc_ready,
    input  p_ready, acc_out, acc_valid, acc_ovf
  );

  modport slave (
    input  clear, len, p_in, p_valid, acc_ready,
    output p_ready, acc_out, acc_valid, acc_ovf
  );

endinterface

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational unsigned saturating adder with carry flag
//
// Purpose: sum = a + b clamped to all-ones when the true sum does not fit.
// Ports:
//   a, b   WIDTH-bit unsigned operands
//   sum    WIDTH-bit saturated result
//   carry  1 when the unsaturated sum overflowed WIDTH bits
module sat_adder #(
  parameter int WIDTH = mult_pkg::ACC_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[WIDTH];
    sum   = carry ? '1 : raw[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - run-length saturating accumulator of multiplier products
//
// Purpose: sums a run of len products into a saturating accumulator and
// presents each finished sum on a valid/ready result port.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mult_accumulator_if slave: clear, len, p_in/p_valid/p_ready,
//         acc_out/acc_valid/acc_ready, acc_ovf
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int P_WIDTH   = P_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mult_accumulator_if.slave  bus
);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 ovf;
  logic                 run_ovf;
  // One bit wider than len so a run of 2^LEN_WIDTH-1 never wraps.
  logic [LEN_WIDTH:0]   cnt;
  logic [LEN_WIDTH:0]   cnt_inc;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 accept;

  assign p_ext   = ACC_WIDTH'(bus.p_in);
  assign cnt_inc = cnt + (LEN_WIDTH+1)'(1);
  assign run_ovf = ovf | carry;

  // Depends on state only, so upstream can never create a loop through p_valid.
  assign bus.p_ready = !rst && (state != HOLD);
  assign accept      = bus.p_valid && bus.p_ready;

  sat_adder #(.WIDTH(ACC_WIDTH)) u_sat_adder (
    .a     (acc),
    .b     (p_ext),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      len_q         <= '0;
      ovf           <= 1'b0;
      bus.acc_out   <= '0;
      bus.acc_valid <= 1'b0;
      bus.acc_ovf   <= 1'b0;
    end else if (bus.clear) begin
      // Abort wins over every transition; a product offered now is dropped.
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.acc_out   <= '0;
      bus.acc_valid <= 1'b0;
      bus.acc_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= p_ext;
            ovf <= 1'b0;
            cnt <= (LEN_WIDTH+1)'(1);
            if (bus.len <= LEN_WIDTH'(1)) begin
              // Single-product run (len 0 is treated as 1).
              len_q         <= LEN_WIDTH'(1);
              state         <= HOLD;
              bus.acc_out   <= p_ext;
              bus.acc_ovf   <= 1'b0;
              bus.acc_valid <= 1'b1;
            end else begin
              len_q <= bus.len;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum;
            ovf <= run_ovf;
            cnt <= cnt_inc;
            if (cnt_inc == {1'b0, len_q}) begin
              state         <= HOLD;
              bus.acc_out   <= sum;
              bus.acc_ovf   <= run_ovf;
              bus.acc_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            state         <= IDLE;
            bus.acc_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - self-checking bench for mult_accumulator
module tb_mult_accumulator;
  import mult_pkg::*;

  typedef struct {
    logic [39:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [31:0] p_in = 32'd0;
  logic        p_valid = 1'b0;
  logic        acc_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int exp_xfers = 0;

  exp_t exp_q[$];
  exp_t exp33_q[$];

  always #5 clk = ~clk;

  mult_accumulator_if #(.P_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8)) bus ();
  mult_accumulator_if #(.P_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) bus33 ();

  assign bus.clear       = clear;
  assign bus.len         = len;
  assign bus.p_in        = p_in;
  assign bus.p_valid     = p_valid;
  assign bus.acc_ready   = acc_ready;
  assign bus33.clear     = clear;
  assign bus33.len       = len;
  assign bus33.p_in      = p_in;
  assign bus33.p_valid   = p_valid;
  assign bus33.acc_ready = acc_ready;

  mult_accumulator #(.P_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mult_accumulator #(.P_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) dut33 (
    .clk (clk),
    .rst (rst),
    .bus (bus33)
  );

  always @(posedge clk) begin
    if (bus.acc_valid && acc_ready) xfers <= xfers + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t model(input logic [31:0] pq[$], input int w);
    exp_t        r;
    logic [63:0] s;
    logic [63:0] mx;
    s     = 64'd0;
    r.ovf = 1'b0;
    mx    = (64'd1 << w) - 64'd1;
    foreach (pq[i]) begin
      s = s + 64'(pq[i]);
      if (s > mx) begin
        s     = mx;
        r.ovf = 1'b1;
      end
    end
    r.acc = s[39:0];
    return r;
  endfunction

  // Offer one product starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] d);
    int n = 0;
    p_valid = 1'b1;
    p_in    = d;
    while (!bus.p_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.p_ready) begin
      errors++;
      $display("FAIL send_timeout: p_ready=%b required 1", bus.p_ready);
    end
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic run(input int l, input logic [31:0] pq[$], input int gq[$]);
    len = 8'(l);
    exp_q.push_back(model(pq, 40));
    exp33_q.push_back(model(pq, 33));
    foreach (pq[i]) begin
      if (i < gq.size()) repeat (gq[i]) @(negedge clk);
      send(pq[i]);
    end
  endtask

  task automatic take_result(output logic [39:0] a, output logic o,
                             output logic [32:0] a33, output logic o33,
                             output logic ok);
    int n = 0;
    while (!bus.acc_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok  = bus.acc_valid;
    a   = bus.acc_out;
    o   = bus.acc_ovf;
    a33 = bus33.acc_out;
    o33 = bus33.acc_ovf;
    if (ok) begin
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      exp_xfers++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.acc_out !== 40'd0 || bus.acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b out=%h ovf=%b required 0/0/0",
               bus.acc_valid, bus.acc_out, bus.acc_ovf);
    end
    checks++;
    if (bus.p_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_p_ready: got %b required 0", bus.p_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.p_ready !== 1'b1 || bus.acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: p_ready=%b acc_valid=%b required 1/0", bus.p_ready, bus.acc_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] pq[$];
    int          gq[$];
    logic [39:0] a;
    logic [32:0] a33;
    logic        o, o33, ok;
    exp_t        e, e33;
    pq = {32'd1, 32'd2, 32'd3, 32'd4};
    gq = {};
    run(4, pq, gq);
    checks++;
    if (bus.acc_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: acc_valid=%b required 1 right after last accept", bus.acc_valid);
    end
    take_result(a, o, a33, o33, ok);
    e   = exp_q.pop_front();
    e33 = exp33_q.pop_front();
    checks++;
    if (!ok || a !== e.acc || o !== e.ovf || e.acc !== 40'd10) begin
      errors++;
      $display("FAIL basic_sum: got %h ovf %b required %h ovf %b", a, o, e.acc, e.ovf);
    end
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: acc_valid=%b p_ready=%b required 0/1", bus.acc_valid, bus.p_ready);
    end
  endtask

  task automatic test_len01();
    logic [31:0] pq[$];
    int          gq[$];
    logic [39:0] a;
    logic [32:0] a33;
    logic        o, o33, ok;
    exp_t        e, e33;
    for (int l = 0; l < 2; l++) begin
      pq = {32'hFFFE_0001};
      gq = {};
      run(l, pq, gq);
      checks++;
      if (bus.acc_valid !== 1'b1) begin
        errors++;
        $display("FAIL len%0d_latency: acc_valid=%b required 1", l, bus.acc_valid);
      end
      take_result(a, o, a33, o33, ok);
      e   = exp_q.pop_front();
      e33 = exp33_q.pop_front();
      checks++;
      if (!ok || a !== e.acc || o !== 1'b0 || a !== 40'h00_FFFE_0001) begin
        errors++;
        $display("FAIL len%0d_value: got %h ovf %b required %h ovf 0", l, a, o, e.acc);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] pq[$];
    int          gq[$];
    logic [39:0] a;
    logic [32:0] a33;
    logic        o, o33, ok;
    exp_t        e, e33;
    pq = {};
    gq = {};
    for (int i = 0; i < 255; i++) pq.push_back(32'hFFFF_FFFF);
    run(255, pq, gq);
    take_result(a, o, a33, o33, ok);
    e   = exp_q.pop_front();
    e33 = exp33_q.pop_front();
    checks++;
    if (!ok || a !== e.acc || o !== e.ovf || a !== 40'hFE_FFFF_FF01) begin
      errors++;
      $display("FAIL sat40: got %h ovf %b required %h ovf %b", a, o, e.acc, e.ovf);
    end
    checks++;
    if (!ok || a33 !== e33.acc[32:0] || o33 !== 1'b1 || a33 !== 33'h1_FFFF_FFFF) begin
      errors++;
      $display("FAIL sat33: got %h ovf %b required %h ovf 1", a33, o33, e33.acc[32:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pq[$];
    int          gq[$];
    logic [39:0] a;
    logic [32:0] a33;
    logic        o, o33, ok;
    exp_t        e, e33;
    int          bad;
    pq = {32'd7, 32'd8};
    gq = {};
    run(2, pq, gq);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.acc_valid !== 1'b1 || bus.p_ready !== 1'b0 || bus.acc_out !== exp_q[0].acc) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b p_ready=%b out=%h required 1/0/%h",
                 i, bus.acc_valid, bus.p_ready, bus.acc_out, exp_q[0].acc);
      end
      @(negedge clk);
    end
    take_result(a, o, a33, o33, ok);
    e   = exp_q.pop_front();
    e33 = exp33_q.pop_front();
    checks++;
    if (!ok || a !== e.acc || o !== e.ovf) begin
      errors++;
      $display("FAIL bp_value: got %h required %h", a, e.acc);
    end
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: acc_valid=%b p_ready=%b required 0/1", bus.acc_valid, bus.p_ready);
    end
  endtask

  task automatic test_stalls();
    logic [31:0] pq[$];
    logic [39:0] a;
    logic [32:0] a33;
    logic        o, o33, ok;
    exp_t        e, e33;
    pq = {32'd10, 32'd20, 32'd30};
    exp_q.push_back(model(pq, 40));
    exp33_q.push_back(model(pq, 33));
    len = 8'd3;
    send(pq[0]);
    len = 8'd1;  // must be ignored mid-run
    send(pq[1]);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_midrun: acc_valid=%b p_ready=%b required 0/1", bus.acc_valid, bus.p_ready);
    end
    repeat (7) @(negedge clk);
    send(pq[2]);
    take_result(a, o, a33, o33, ok);
    e   = exp_q.pop_front();
    e33 = exp33_q.pop_front();
    checks++;
    if (!ok || a !== e.acc || a !== 40'd60) begin
      errors++;
      $display("FAIL stall_sum: got %h required %h", a, e.acc);
    end
  endtask

  task automatic test_clear();
    logic [31:0] pq[$];
    int          gq[$];
    logic [39:0] a;
    logic [32:0] a33;
    logic        o, o33, ok;
    exp_t        e, e33;
    int          pulses;
    len = 8'd4;
    send(32'd100);
    send(32'd200);
    clear   = 1'b1;
    p_valid = 1'b1;
    p_in    = 32'd999;
    @(negedge clk);
    clear   = 1'b0;
    p_valid = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.acc_valid) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0 || bus.p_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_abort: valid cycles=%0d p_ready=%b required 0/1", pulses, bus.p_ready);
    end
    pq = {32'd5, 32'd6};
    gq = {};
    run(2, pq, gq);
    take_result(a, o, a33, o33, ok);
    e   = exp_q.pop_front();
    e33 = exp33_q.pop_front();
    checks++;
    if (!ok || a !== e.acc || a !== 40'd11) begin
      errors++;
      $display("FAIL clear_fresh_run: got %h required %h", a, e.acc);
    end
    // clear while a result is held discards it
    len = 8'd1;
    send(32'd42);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.acc_ovf !== 1'b0 || bus.acc_out !== 40'd0 || bus.p_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_hold: valid=%b ovf=%b out=%h p_ready=%b required 0/0/0/1",
               bus.acc_valid, bus.acc_ovf, bus.acc_out, bus.p_ready);
    end
  endtask

  task automatic test_reset_hold();
    len = 8'd1;
    send(32'd77);
    checks++;
    if (bus.acc_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_setup: acc_valid=%b required 1", bus.acc_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b0 || bus.acc_out !== 40'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b p_ready=%b out=%h required 0/0/0",
               bus.acc_valid, bus.p_ready, bus.acc_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.p_ready !== 1'b1 || bus.acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: p_ready=%b valid=%b required 1/0", bus.p_ready, bus.acc_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len01();
    test_saturation();
    test_backpressure();
    test_stalls();
    test_clear();
    test_reset_hold();
    @(negedge clk);
    checks++;
    if (xfers != exp_xfers || exp_q.size() != 0) begin
      errors++;
      $display("FAIL transfer_count: got %0d transfers, %0d pending required %0d, 0",
               xfers, exp_q.size(), exp_xfers);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream stage of the 16x16 unsigned multiplier top.
- The multiplier has a fixed 2-cycle latency and no handshake. A caller-side 2-deep valid delay line aligns p_valid with p_in.
- This block sums a programmable-length run of 32-bit unsigned products into a saturating 40-bit accumulator.
- It presents each finished sum on a valid/ready output port, giving dot-product / FIR-tap results to the consumer.

Parameters:
- P_WIDTH, 32, width of incoming product.
- ACC_WIDTH, 40, accumulator and result width; must be >= P_WIDTH.
- LEN_WIDTH, 8, width of the run-length input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards any partial run and any held result.
- len  input  LEN_WIDTH  number of products per run. Sampled on the first accepted product of a run. 0 is treated as 1.
- p_in  input  P_WIDTH  product from the multiplier.
- p_valid  input  1  p_in is valid this cycle.
- p_ready  output  1  block can accept p_in this cycle.
- acc_out  output  ACC_WIDTH  completed (possibly saturated) sum.
- acc_valid  output  1  acc_out is valid.
- acc_ready  input  1  consumer accepts acc_out.
- acc_ovf  output  1  saturation occurred during the run that produced acc_out.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE.
  - acc=0, cnt=0, len_q=0.
  - acc_out=0, acc_valid=0, acc_ovf=0, p_ready=0 while rst is asserted.
- Handshake:
  - A product is accepted when p_valid and p_ready are both 1.
  - A result is taken when acc_valid and acc_ready are both 1.
  - p_ready=1 in IDLE and ACCUM, 0 in HOLD. It is combinational from state only, never from p_valid.
- States:
  - IDLE:
    - On accept: len_q = (len==0 ? 1 : len); acc = zero-extended p_in; ovf=0; cnt=1.
    - If len_q==1, go to HOLD; otherwise go to ACCUM.
  - ACCUM:
    - On accept: acc = sat(acc + p_in); cnt = cnt+1; ovf |= carry-out.
    - When the accepted product makes cnt==len_q, go to HOLD.
    - p_valid=0 is a stall: no state change.
  - HOLD:
    - acc_out=acc, acc_valid=1, acc_ovf=ovf. All three are registered.
    - acc_out and acc_ovf stay stable while acc_ready=0.
    - When acc_ready=1, go to IDLE next cycle with acc_valid=0.
- Latency: acc_valid rises on the clock edge after the last product is accepted. Minimum one bubble between runs, because HOLD has p_ready=0.
- Throughput: a run of N products occupies N+1 cycles, plus consumer stall cycles.
- Saturation:
  - Addition is performed at ACC_WIDTH+1 bits.
  - If the top bit is set, acc = all-ones and ovf=1.
  - Once saturated, acc stays all-ones for the rest of the run.
- len is ignored mid-run; only len_q governs run length.
- cnt is LEN_WIDTH+1 bits, so len=2^LEN_WIDTH-1 never wraps.
- clear:
  - Has priority over every transition.
  - Next cycle: state=IDLE, acc=0, cnt=0, acc_valid=0, acc_ovf=0.
  - A product presented in the same cycle as clear is dropped, even if p_ready was 1.
- Reset mid-run or mid-HOLD: the partial sum and any pending result are lost, with no output pulse.
- Simultaneous HOLD-exit and new product: not possible, because p_ready=0 in HOLD. The upstream holds p_valid.

Decomposition:
- Shared package mult_pkg holds:
  - P_WIDTH/ACC_WIDTH/LEN_WIDTH defaults.
  - The state enum (IDLE, ACCUM, HOLD).
  - The ACC_MAX constant (all-ones).
- One sub-module, sat_adder, is natural: a combinational ACC_WIDTH saturating adder with carry flag, reusable by later reduction stages.

Test Plan:
- Basic run:
  - Stimulus: len=4, products 0x0000_0001, 0x0000_0002, 0x0000_0003, 0x0000_0004 back-to-back.
  - Response: acc_valid rises on the cycle after the 4th accept; acc_out=10, acc_ovf=0; then IDLE.
- len=0 and len=1:
  - Stimulus: single product 0xFFFE_0001 (0xFFFF*0xFFFF).
  - Response: acc_out=0x00_FFFE_0001 one cycle later, for both len values.
- Saturation:
  - Stimulus: len=255, all products 0xFFFF_FFFF, with ACC_WIDTH=33 override.
  - Response: acc_out=0x1_FFFF_FFFF, acc_ovf=1.
  - Repeat with default ACC_WIDTH=40: no overflow; acc_out = 255*0xFFFF_FFFF = 0xFE_FFFF_FF01.
- Backpressure:
  - Stimulus: acc_ready=0 for 5 cycles after result.
  - Response: acc_out stable, p_ready=0 throughout. On acc_ready=1, one transfer, then p_ready=1.
- Stalls:
  - Stimulus: len=3 with p_valid gaps of 0, 2, 7 cycles.
  - Response: correct sum; cnt unaffected by idle cycles.
- clear/reset:
  - Stimulus: clear after 2 of 4 products, then a fresh len=2 run of 5 and 6.
  - Response: acc_out=11, no output pulse for the aborted run.
  - Stimulus: assert rst asynchronously mid-HOLD.
  - Response: acc_valid drops immediately.
